spy_delay_sensor: RTL

Parametrised launch/capture delay sensor built on a keep-protected chain of inverting stages. It repeatedly launches a transition into the chain and captures the taps one clock later. From each capture it derives the propagation depth and accumulates sum/min/max over a programmable number of samples. It sits beside the fixed-length spy path chains as the self-timed measurement front end that the host polls over a valid/ready result port.

---
 rtl/spy_delay_sensor_pkg.sv | 24 ++
 rtl/spy_delay_stage.sv | 15 +
 rtl/spy_delay_sensor.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/spy_delay_sensor_pkg.sv
// Shared definitions for spy_delay_sensor: FSM encoding, result-width helper, parameter legality.
package spy_delay_sensor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_LAUNCH,
        ST_CAPTURE,
        ST_DECODE,
        ST_DONE
    } state_e;

    // Depth ranges over 0..num_taps inclusive.
    function automatic int depth_width(input int num_taps);
        return $clog2(num_taps + 1);
    endfunction

    function automatic bit params_legal(input int chain_len, input int tap_stride,
                                        input int settle_cycles);
        return (tap_stride > 0) && (chain_len > 0) &&
               ((chain_len % tap_stride) == 0) && (settle_cycles >= 1);
    endfunction

endpackage

// File: rtl/spy_delay_stage.sv
// One inverting delay element; keep attributes stop synthesis from collapsing the chain.
// Purely combinational, no flow control.
module spy_delay_stage (
    input  logic a_i,
    output logic y_o
);

    (* keep = "true" *) logic a_k;
    (* keep = "true" *) logic y_k;

    assign a_k = a_i;
    assign y_k = ~a_k;
    assign y_o = y_k;

endmodule

// File: rtl/spy_delay_sensor.sv
// Launch/capture delay sensor: n*(SETTLE_CYCLES+3) cycles per run, result held in DONE until res_ready_i.
// Optional SPY_BUBBLE_EN adds non-thermometer capture counting; otherwise res_bubbles_o is 0.
module spy_delay_sensor
    import spy_delay_sensor_pkg::*;
#(
    parameter  int CHAIN_LEN     = 64,
    parameter  int TAP_STRIDE    = 1,
    parameter  int SETTLE_CYCLES = 4,
    parameter  int SAMPLE_W      = 8,
    localparam int NUM_TAPS      = CHAIN_LEN / TAP_STRIDE,
    localparam int DEPTH_W       = depth_width(NUM_TAPS),
    localparam int SUM_W         = DEPTH_W + SAMPLE_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [SAMPLE_W-1:0] n_samples_i,
    output logic                busy_o,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [SUM_W-1:0]    res_sum_o,
    output logic [DEPTH_W-1:0]  res_min_o,
    output logic [DEPTH_W-1:0]  res_max_o,
    output logic [SAMPLE_W-1:0] res_bubbles_o
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    if (!params_legal(CHAIN_LEN, TAP_STRIDE, SETTLE_CYCLES)) begin : g_param_check
        $error("spy_delay_sensor: CHAIN_LEN must be a multiple of TAP_STRIDE and SETTLE_CYCLES >= 1");
    end

    state_e              state_q;
    logic                launch_q;
    logic [NUM_TAPS-1:0] cap_q;
    logic                busy_q;
    logic                valid_q;
    logic [SAMPLE_W-1:0] n_q;
    logic [SAMPLE_W-1:0] cnt_q;
    logic [SET_W-1:0]    settle_q;
    logic [SUM_W-1:0]    sum_q;
    logic [DEPTH_W-1:0]  min_q;
    logic [DEPTH_W-1:0]  max_q;

    logic [NUM_TAPS-1:0] tap_w;
    logic [NUM_TAPS-1:0] taps;

    // Each stage owns its output net so the chain never forms a self-referencing vector.
    for (genvar i = 0; i < CHAIN_LEN; i++) begin : g_stage
        logic a;
        logic y;
        if (i == 0) begin : g_head
            assign a = launch_q;
        end else begin : g_link
            assign a = g_stage[i-1].y;
        end
        spy_delay_stage u_stage (
            .a_i (a),
            .y_o (y)
        );
        if (((i + 1) % TAP_STRIDE) == 0) begin : g_tap
            assign tap_w[(i + 1) / TAP_STRIDE - 1] = y;
        end
    end

    assign taps = tap_w;

    logic [NUM_TAPS-1:0] exp_pat;
    logic [NUM_TAPS-1:0] settled;
    logic [DEPTH_W-1:0]  depth;
    logic                run;
    logic                bubble;

    // Tap k sits after stage (k+1)*TAP_STRIDE-1; an odd stage count inverts the launch level.
    always_comb begin
        exp_pat = '0;
        depth   = '0;
        run     = 1'b1;
        bubble  = 1'b0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            exp_pat[k] = launch_q ^ ((((k + 1) * TAP_STRIDE) % 2) != 0);
        end
        settled = ~(cap_q ^ exp_pat);
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (!settled[k]) begin
                run = 1'b0;
            end else if (run) begin
                depth = depth + DEPTH_W'(1);
            end else begin
                bubble = 1'b1;
            end
        end
    end

    logic [SUM_W-1:0]   sum_d;
    logic [DEPTH_W-1:0] min_d;
    logic [DEPTH_W-1:0] max_d;

    assign sum_d = sum_q + SUM_W'(depth);
    assign min_d = (depth < min_q) ? depth : min_q;
    assign max_d = (depth > max_q) ? depth : max_q;

`ifdef SPY_BUBBLE_EN
    logic [SAMPLE_W-1:0] bub_q;
    logic [SAMPLE_W-1:0] bub_d;

    assign bub_d = (bubble && (bub_q != '1)) ? bub_q + SAMPLE_W'(1) : bub_q;
`else
    logic unused_bubble;
    assign unused_bubble = bubble;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            launch_q <= 1'b0;
            cap_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            n_q      <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
            sum_q    <= '0;
            min_q    <= '0;
            max_q    <= '0;
`ifdef SPY_BUBBLE_EN
            bub_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        n_q      <= (n_samples_i == '0) ? SAMPLE_W'(1) : n_samples_i;
                        cnt_q    <= '0;
                        settle_q <= '0;
                        sum_q    <= '0;
                        min_q    <= '1;
                        max_q    <= '0;
`ifdef SPY_BUBBLE_EN
                        bub_q    <= '0;
`endif
                        busy_q   <= 1'b1;
                        state_q  <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                        settle_q <= '0;
                        state_q  <= ST_LAUNCH;
                    end else begin
                        settle_q <= settle_q + SET_W'(1);
                    end
                end
                ST_LAUNCH: begin
                    launch_q <= ~launch_q;
                    state_q  <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    cap_q   <= taps;
                    state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    sum_q <= sum_d;
                    min_q <= min_d;
                    max_q <= max_d;
`ifdef SPY_BUBBLE_EN
                    bub_q <= bub_d;
`endif
                    if (cnt_q == n_q - SAMPLE_W'(1)) begin
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q   <= cnt_q + SAMPLE_W'(1);
                        state_q <= ST_PREP;
                    end
                end
                ST_DONE: begin
                    if (res_ready_i) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign res_valid_o = valid_q;
    assign res_sum_o   = sum_q;
    assign res_min_o   = min_q;
    assign res_max_o   = max_q;
`ifdef SPY_BUBBLE_EN
    assign res_bubbles_o = bub_q;
`else
    assign res_bubbles_o = '0;
`endif

endmodule
